// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply-divide unit.
// Also used by ID decode to classify MDU instructions.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic {
    MDU_SEL_LO = 1'b0,
    MDU_SEL_HI = 1'b1
  } mdu_sel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  localparam int MDU_CNT_W       = 16;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational HI/LO result for MULT/MULTU/DIV/DIVU.
// Signed divide runs on magnitudes, then fixes signs.
module mdu_compute
  import mult_div_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic        is_mult;
  logic        is_multu;
  logic        is_div;
  logic        is_divu;
  logic [63:0] a_sx;
  logic [63:0] b_sx;
  logic [63:0] a_zx;
  logic [63:0] b_zx;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] uq;
  logic [31:0] ur;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] quo;
  logic [31:0] rem;

  assign is_mult  = (op == MDU_MULT);
  assign is_multu = (op == MDU_MULTU);
  assign is_div   = (op == MDU_DIV);
  assign is_divu  = (op == MDU_DIVU);

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign a_zx   = {32'd0, a};
  assign b_zx   = {32'd0, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  assign abs_a = a[31] ? (32'd0 - a) : a;
  assign abs_b = b[31] ? (32'd0 - b) : b;
  assign dvd   = is_div ? abs_a : a;
  // Zero divisor is replaced so the divider never yields X.
  assign dvs   = (b == 32'd0) ? 32'd1 : (is_div ? abs_b : b);
  assign uq    = dvd / dvs;
  assign ur    = dvd % dvs;
  assign neg_q = is_div && (a[31] ^ b[31]);
  assign neg_r = is_div && a[31];
  assign quo   = neg_q ? (32'd0 - uq) : uq;
  assign rem   = neg_r ? (32'd0 - ur) : ur;

  always_comb begin
    res_hi      = '0;
    res_lo      = '0;
    div_by_zero = 1'b0;
    unique case (1'b1)
      is_mult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      is_multu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      is_div, is_divu: begin
        res_hi      = rem;
        res_lo      = quo;
        div_by_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage HI/LO multiply-divide unit with fixed latency.
// Result is computed at start and committed after the count.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall_req
);

  mdu_state_t           state;
  logic [MDU_CNT_W-1:0] cnt;
  logic [MDU_CNT_W-1:0] lat;
  logic [31:0]          hi;
  logic [31:0]          lo;
  logic [31:0]          pend_hi;
  logic [31:0]          pend_lo;
  logic                 pend_dz;
  logic [31:0]          res_hi;
  logic [31:0]          res_lo;
  logic                 res_dz;
  logic                 md_start;

  mdu_compute u_compute (
    .op          (op),
    .a           (a),
    .b           (b),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (res_dz)
  );

  assign md_start  = start && is_muldiv(op);
  assign stall_req = busy || md_start;
  assign rd_data   = (rd_sel == MDU_SEL_HI) ? hi : lo;
  assign lat       = is_mul(op) ? MDU_CNT_W'(MULT_CYCLES)
                                : MDU_CNT_W'(DIV_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (md_start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_dz <= res_dz;
            cnt     <= lat;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end else if (start && op == MDU_MTHI) begin
            hi <= a;
          end else if (start && op == MDU_MTLO) begin
            lo <= a;
          end
        end
        ST_RUN: begin
          if (cnt == MDU_CNT_W'(1)) begin
            // Divide by zero leaves HI/LO untouched.
            if (!pend_dz) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - MDU_CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
